// File: rtl/life_frame_scheduler.sv
// Frame sequencer: calc step -> buffer swap -> WS2812 send -> latch gap, paced at FRAME_TICKS per generation.
// Latency: calc_start one cycle after the IDLE/WAIT exit decision; step_n fall to calc_start within 3 cycles.
// Backpressure: holds in CALC/SEND until calc_done/tx_done; LIFE_SCHED_WATCHDOG_EN adds a sticky timeout fault.
module life_frame_scheduler #(
  parameter int FRAME_TICKS   = 6000000,
  parameter int LATCH_TICKS   = 3600,
  parameter int TIMEOUT_TICKS = 1200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step_n,
  output logic        calc_start,
  input  logic        calc_done,
  output logic        buf_sel,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        busy,
  output logic [2:0]  state,
  output logic [15:0] gen_count,
  output logic        fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    SWAP  = 3'd2,
    SEND  = 3'd3,
    LATCH = 3'd4,
    WAIT  = 3'd5
  } state_t;

  localparam int FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int LW = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_TICKS - 1);

  state_t        state_q, state_d;
  logic          entry_q;
  logic          shown_q;
  logic [FW-1:0] frame_cnt;
  logic [LW-1:0] latch_cnt;
  logic          step_s1, step_s2, step_s3;
  logic          step_edge;
  logic          calc_ok, tx_ok, latch_end, wd_expire;

  // entry_q marks the first cycle of a state; a done pulse coinciding with its start is discarded
  assign step_edge = step_s3 & ~step_s2;
  assign calc_ok   = calc_done & ~entry_q;
  assign tx_ok     = tx_done & ~entry_q;
  assign latch_end = (latch_cnt == LATCH_LAST);

`ifdef LIFE_SCHED_WATCHDOG_EN
  localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_TICKS - 1);

  logic [TW-1:0] wd_cnt;
  logic          fault_q;

  assign wd_expire = (wd_cnt == WD_LAST) &&
                     ((state_q == CALC && !calc_ok) || (state_q == SEND && !tx_ok));
  assign fault = fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state_q == CALC || state_q == SEND) wd_cnt <= wd_cnt + 1'b1;
      else                                    wd_cnt <= '0;
      fault_q <= fault_q | wd_expire;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_TICKS;
  assign wd_expire      = 1'b0;
  assign fault          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fault) begin
          if (!shown_q)              state_d = SEND;
          else if (run || step_edge) state_d = CALC;
        end
      end
      CALC: begin
        if (wd_expire)    state_d = IDLE;
        else if (calc_ok) state_d = SWAP;
      end
      SWAP: state_d = SEND;
      SEND: begin
        if (wd_expire)  state_d = IDLE;
        else if (tx_ok) state_d = LATCH;
      end
      LATCH: begin
        if (latch_end) state_d = run ? WAIT : IDLE;
      end
      WAIT: begin
        if (!run)                         state_d = IDLE;
        else if (frame_cnt >= FRAME_LAST) state_d = CALC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      entry_q   <= 1'b0;
      shown_q   <= 1'b0;
      frame_cnt <= '0;
      latch_cnt <= '0;
      buf_sel   <= 1'b0;
      gen_count <= '0;
      step_s1   <= 1'b1;
      step_s2   <= 1'b1;
      step_s3   <= 1'b1;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
      step_s1 <= step_n;
      step_s2 <= step_s1;
      step_s3 <= step_s2;

      // frame period is measured from the first CALC cycle, saturating so an overrun exits WAIT at once
      if (state_d == CALC && state_q != CALC) frame_cnt <= '0;
      else if (frame_cnt < FRAME_LAST)        frame_cnt <= frame_cnt + 1'b1;

      if (state_q == LATCH && !latch_end) latch_cnt <= latch_cnt + 1'b1;
      else                                latch_cnt <= '0;

      if (state_q == LATCH && latch_end) shown_q <= 1'b1;

      if (state_q == SWAP) begin
        buf_sel   <= ~buf_sel;
        gen_count <= gen_count + 16'd1;
      end
    end
  end

  assign calc_start = (state_q == CALC) && entry_q;
  assign tx_start   = (state_q == SEND) && entry_q;
  assign busy       = (state_q != IDLE);
  assign state      = state_q;

endmodule

// File: tb/tb_life_frame_scheduler.sv
// Directed bench for life_frame_scheduler with FRAME_TICKS=200, LATCH_TICKS=20, TIMEOUT_TICKS=1000.
// Behavioural engine/transmitter responders pulse done a programmable number of cycles after each start.
module tb_life_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        step_n;
  logic        calc_start;
  logic        calc_done = 1'b0;
  logic        buf_sel;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        busy;
  logic [2:0]  state;
  logic [15:0] gen_count;
  logic        fault;

  always #5 clk = ~clk;

  life_frame_scheduler #(
    .FRAME_TICKS  (200),
    .LATCH_TICKS  (20),
    .TIMEOUT_TICKS(1000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .step_n    (step_n),
    .calc_start(calc_start),
    .calc_done (calc_done),
    .buf_sel   (buf_sel),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .busy      (busy),
    .state     (state),
    .gen_count (gen_count),
    .fault     (fault)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0, n_calc = 0, n_tx = 0, last_calc = 0, period = 0;
  int wait_run = 0, wait_len = 0;
  int calc_dly = 30, tx_dly = 10, calc_cd = 0, tx_cd = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Responders and event recorder, sampled 1 unit after each rising edge.
  // A delay of N puts done high N cycles after the start cycle, so that state spans N+1 cycles.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    calc_done = 1'b0;
    tx_done   = 1'b0;
    if (reset) begin
      calc_cd = 0;
      tx_cd   = 0;
    end
    if (calc_cd > 0) begin
      calc_cd--;
      calc_done = (calc_cd == 0);
    end
    if (tx_cd > 0) begin
      tx_cd--;
      tx_done = (tx_cd == 0);
    end
    if (calc_start) begin
      n_calc++;
      period    = cyc - last_calc;
      last_calc = cyc;
      if (calc_dly > 0) calc_cd = calc_dly;
    end
    if (tx_start) begin
      n_tx++;
      if (tx_dly > 0) tx_cd = tx_dly;
    end
    if (state == 3'd5) wait_run++;
    else if (wait_run > 0) begin
      wait_len = wait_run;
      wait_run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    int i = 0;
    while (state !== s && i < max) begin
      tick(1);
      i++;
    end
    chk(tag, state, s);
  endtask

  task automatic wait_calc(input int target, input int max, input string tag);
    int i = 0;
    while (n_calc < target && i < max) begin
      tick(1);
      i++;
    end
    chk(tag, n_calc, target);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got time %0t, expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int lat;
    int n0;
    int nt;

    reset  = 1'b1;
    run    = 1'b0;
    step_n = 1'b1;
    tick(3);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_buf", buf_sel, 0);
    chk("rst_gen", gen_count, 0);
    chk("rst_calc_start", calc_start, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_fault", fault, 0);
    reset = 1'b0;

    // Seed display after reset, run=0
    wait_state(3'd3, 10, "seed_send");
    chk("seed_tx_start", tx_start, 1);
    chk("seed_buf", buf_sel, 0);
    wait_state(3'd4, 40, "seed_latch");
    lat = 0;
    while (state == 3'd4 && lat < 100) begin
      lat++;
      tick(1);
    end
    chk("latch_len", lat, 20);
    chk("seed_idle", state, 0);
    tick(300);
    chk("seed_n_tx", n_tx, 1);
    chk("seed_no_calc", n_calc, 0);
    chk("seed_buf_end", buf_sel, 0);
    chk("seed_gen_end", gen_count, 0);

    // Free run, within the frame budget: 200-cycle period
    calc_dly = 30;
    tx_dly   = 50;
    run      = 1'b1;
    wait_calc(1, 10, "run_g1_start");
    wait_state(3'd3, 100, "run_g1_send");
    chk("run_g1_buf", buf_sel, 1);
    chk("run_g1_gen", gen_count, 1);
    wait_calc(2, 250, "run_g2_start");
    chk("run_g2_period", period, 200);
    wait_state(3'd3, 100, "run_g2_send");
    chk("run_g2_buf", buf_sel, 0);
    chk("run_g2_gen", gen_count, 2);
    wait_calc(3, 250, "run_g3_start");
    chk("run_g3_period", period, 200);
    wait_state(3'd3, 100, "run_g3_send");
    chk("run_g3_buf", buf_sel, 1);
    chk("run_g3_gen", gen_count, 3);

    // Overrun: CALC 151 + SWAP 1 + SEND 101 + LATCH 20 = 273 > 200, WAIT 1 -> 274
    calc_dly = 150;
    tx_dly   = 100;
    wait_calc(4, 250, "ovr_g4_start");
    chk("ovr_g4_period", period, 200);
    wait_calc(5, 400, "ovr_g5_start");
    chk("ovr_g5_period", period, 274);
    chk("ovr_wait_len", wait_len, 1);
    chk("ovr_g5_gen", gen_count, 4);
    run = 1'b0;
    wait_state(3'd0, 600, "ovr_stop_idle");
    chk("ovr_stop_gen", gen_count, 5);
    chk("ovr_stop_buf", buf_sel, 1);

    // Single step from IDLE; a second step during SEND is dropped
    calc_dly = 30;
    tx_dly   = 50;
    n0       = n_calc;
    step_n   = 1'b0;
    lat      = 0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      if (calc_start && lat == 0) lat = i;
    end
    step_n = 1'b1;
    chk("step_latency_le3", (lat >= 1 && lat <= 3), 1);
    wait_state(3'd3, 100, "step_send");
    step_n = 1'b0;
    tick(5);
    step_n = 1'b1;
    chk("step_still_send", state, 3);
    wait_state(3'd0, 200, "step_idle");
    tick(50);
    chk("step_one_calc", n_calc - n0, 1);
    chk("step_gen", gen_count, 6);

    // Asynchronous reset in the first SEND cycle
    step_n = 1'b0;
    tick(3);
    step_n = 1'b1;
    wait_state(3'd3, 100, "rst_pre_send");
    chk("rst_pre_tx", tx_start, 1);
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_gen", gen_count, 7);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_tx", tx_start, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_buf", buf_sel, 0);
    chk("rst_mid_gen", gen_count, 0);
    chk("rst_mid_state", state, 0);
    tick(3);
    nt    = n_tx;
    reset = 1'b0;
    wait_state(3'd3, 10, "reseed_send");
    chk("reseed_tx", n_tx - nt, 1);
    chk("reseed_buf", buf_sel, 0);
    wait_state(3'd0, 200, "reseed_idle");
    chk("reseed_gen", gen_count, 0);

    // Engine never answers
    calc_dly = 0;
    n0       = n_calc;
    step_n   = 1'b0;
    tick(3);
    step_n = 1'b1;
    wait_calc(n0 + 1, 10, "wd_start");
`ifdef LIFE_SCHED_WATCHDOG_EN
    tick(995);
    chk("wd_fault_early", fault, 0);
    tick(10);
    chk("wd_fault", fault, 1);
    chk("wd_state_idle", state, 0);
    chk("wd_gen_kept", gen_count, 0);
    step_n = 1'b0;
    tick(3);
    step_n = 1'b1;
    tick(50);
    chk("wd_blocked_state", state, 0);
    chk("wd_no_restart", n_calc - n0, 1);
`else
    tick(1100);
    chk("nowd_fault", fault, 0);
    chk("nowd_state_calc", state, 1);
    chk("nowd_no_restart", n_calc - n0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
